// File: rtl/wb_trace_buffer.sv
// Write-back trace capture FIFO with a 5-byte-per-record serializer.
// Optional TRACE_ZERO_FILTER_EN ignores write-backs to register zero.
module wb_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_CPU,
  input  logic                     rst_CPU,
  input  logic                     trace_valid,
  input  logic [4:0]               trace_addr,
  input  logic [31:0]              trace_data,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     byte_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_D3   = 3'd2;
  localparam logic [2:0] S_D2   = 3'd3;
  localparam logic [2:0] S_D1   = 3'd4;
  localparam logic [2:0] S_D0   = 3'd5;

  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [36:0]   hold_q;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;
  logic          evt, pop, push, drop, hs;

`ifdef TRACE_ZERO_FILTER_EN
  assign evt = trace_valid && (trace_addr != 5'd0);
`else
  assign evt = trace_valid;
`endif

  // A pop frees a slot on the same edge, so a full FIFO still accepts then
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign push = evt && ((count_q != FULL_C) || pop);
  assign drop = evt && !push;
  assign hs   = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = S_ADDR;
      S_ADDR:  if (hs)  state_d = S_D3;
      S_D3:    if (hs)  state_d = S_D2;
      S_D2:    if (hs)  state_d = S_D1;
      S_D1:    if (hs)  state_d = S_D0;
      S_D0:    if (hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_data = 8'h00;
    unique case (state_q)
      S_ADDR:  byte_data = {3'b000, hold_q[36:32]};
      S_D3:    byte_data = hold_q[31:24];
      S_D2:    byte_data = hold_q[23:16];
      S_D1:    byte_data = hold_q[15:8];
      S_D0:    byte_data = hold_q[7:0];
      default: byte_data = 8'h00;
    endcase
  end

  assign byte_valid = (state_q != IDLE);
  assign byte_last  = (state_q == S_D0);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (AW+1)'(1);
    else if (pop && !push)
      count_d = count_q - (AW+1)'(1);
  end

  // A drop on the clearing edge counts as the first drop after the clear
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clear_ovf ? 8'd1 :
               (drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1;
    end else if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk_CPU) begin
    if (push)
      mem_q[wr_ptr_q] <= {trace_addr, trace_data};
  end

  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      hold_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

endmodule
